// File: rtl/loader_pkg.sv
// Shared types and command codes for the byte-stream program loader.
package loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_COUNT,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_RUN_START,
    S_RUN_WAIT
  } loader_state_t;

  localparam logic [7:0] CMD_LOAD_I = 8'h01;
  localparam logic [7:0] CMD_LOAD_D = 8'h02;
  localparam logic [7:0] CMD_RUN    = 8'h03;

endpackage

// File: rtl/prog_loader.sv
// Parses framed load/run commands from a byte stream, writes instruction ROM
// and data memory, and runs the core through its start/halt handshake.
module prog_loader
  import loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [8:0]  imem_wdata,
  output logic        dmem_we,
  output logic [7:0]  dmem_addr,
  output logic [7:0]  dmem_wdata,
  output logic        start,
  input  logic        halt_program,
  output logic        busy,
  output logic        done,
  output logic        err
);

  loader_state_t r_state;
  loader_state_t w_next_state;

  logic        r_is_instr;
  logic [15:0] r_addr;
  logic [8:0]  r_cnt;
  logic [7:0]  r_sum;
  logic        r_hi;
  logic        r_err;
  logic        r_done;
  logic        r_imem_we;
  logic [15:0] r_imem_addr;
  logic [8:0]  r_imem_wdata;
  logic        r_dmem_we;
  logic [7:0]  r_dmem_addr;
  logic [7:0]  r_dmem_wdata;

  logic w_accept;
  logic w_load_cmd;
  logic w_last_word;
  logic [7:0] w_sum_next;

  assign rx_ready    = (r_state != S_RUN_START) && (r_state != S_RUN_WAIT);
  assign busy        = (r_state != S_IDLE);
  assign start       = (r_state == S_RUN_START);
  assign w_accept    = rx_valid && rx_ready;
  assign w_load_cmd  = (rx_data == CMD_LOAD_I) || (rx_data == CMD_LOAD_D);
  assign w_last_word = (r_cnt == 9'd1);
  assign w_sum_next  = r_sum + rx_data;

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign done       = r_done;
  assign err        = r_err;

  // NOTE: next state gets a default before the case so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_load_cmd)              w_next_state = S_ADDR_HI;
        else if (w_accept && rx_data == CMD_RUN) w_next_state = S_RUN_START;
      end
      S_ADDR_HI: if (w_accept) w_next_state = S_ADDR_LO;
      S_ADDR_LO: if (w_accept) w_next_state = S_COUNT;
      S_COUNT:   if (w_accept) w_next_state = r_is_instr ? S_DATA_HI : S_DATA_LO;
      S_DATA_HI: if (w_accept) w_next_state = S_DATA_LO;
      S_DATA_LO: begin
        if (w_accept) begin
          if (w_last_word)     w_next_state = S_CHECK;
          else if (r_is_instr) w_next_state = S_DATA_HI;
          else                 w_next_state = S_DATA_LO;
        end
      end
      S_CHECK:     if (w_accept) w_next_state = S_IDLE;
      S_RUN_START: w_next_state = S_RUN_WAIT;
      S_RUN_WAIT:  if (halt_program) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Reset also drops any write strobe that was pending for the next cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_is_instr   <= 1'b0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_sum        <= '0;
      r_hi         <= 1'b0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else begin
      r_imem_we <= 1'b0;
      r_dmem_we <= 1'b0;
      if (w_accept) r_sum <= w_sum_next;

      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sum <= rx_data;
            if (w_load_cmd || rx_data == CMD_RUN) begin
              r_err      <= 1'b0;
              r_done     <= 1'b0;
              r_is_instr <= (rx_data == CMD_LOAD_I);
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ADDR_HI: if (w_accept) r_addr[15:8] <= rx_data;
        S_ADDR_LO: if (w_accept) r_addr[7:0]  <= rx_data;
        S_COUNT:   if (w_accept) r_cnt <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        S_DATA_HI: begin
          if (w_accept) begin
            r_hi <= rx_data[0];
            if (|rx_data[7:1]) r_err <= 1'b1;
          end
        end
        S_DATA_LO: begin
          if (w_accept) begin
            if (r_is_instr) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_addr;
              r_imem_wdata <= {r_hi, rx_data};
            end else begin
              r_dmem_we    <= 1'b1;
              r_dmem_addr  <= r_addr[7:0];
              r_dmem_wdata <= rx_data;
            end
            r_addr <= r_addr + 16'd1;
            r_cnt  <= r_cnt - 9'd1;
          end
        end
        S_CHECK:    if (w_accept && w_sum_next != 8'h00) r_err <= 1'b1;
        S_RUN_WAIT: if (halt_program) r_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame stream checked against a write-list model built from the frame contents.
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [8:0]  imem_wdata;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        start;
  logic        halt_program = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  always #5 CLK = ~CLK;

  prog_loader dut (
    .CLK(CLK), .RST_N(RST_N),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .start(start), .halt_program(halt_program),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic        is_i;
    logic [15:0] addr;
    logic [8:0]  data;
    logic [31:0] cyc;
  } wr_t;

  int   n_total = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   gaps = 1'b0;
  wr_t  exp_q[$];
  wr_t  obs_q[$];
  logic [8:0] frame_words[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (imem_we) obs_q.push_back(wr_t'{1'b1, imem_addr, imem_wdata, 32'(cyc)});
    if (dmem_we) obs_q.push_back(wr_t'{1'b0, {8'h00, dmem_addr}, {1'b0, dmem_wdata}, 32'(cyc)});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    rx_data  = b;
    rx_valid = 1'b1;
    check("rx_ready_at_byte", rx_ready, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1);
    check({tag, "_outs"}, {imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr,
                           dmem_wdata, start, busy, done, err}, 0);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check({tag, "_write"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // Streams one load frame built from frame_words; expected writes follow the frame rules.
  task automatic load_frame(input logic is_i, input logic [15:0] addr, input bit bad_hi, input bit bad_sum);
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [8:0]  w;
    logic [15:0] ea;
    logic [8:0]  ed;
    int n;
    n = frame_words.size();
    b = is_i ? 8'h01 : 8'h02;
    sum = b;
    send_byte(b);
    check("cmd_clears_err", err, 0);
    check("cmd_clears_done", done, 0);
    check("busy_in_frame", busy, 1);
    send_byte(addr[15:8]); sum += addr[15:8];
    send_byte(addr[7:0]);  sum += addr[7:0];
    b = 8'(n);
    send_byte(b); sum += b;
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      if (is_i) begin
        b = {7'h00, w[8]};
        if (bad_hi && i == n - 1) b = b | 8'h80;
        send_byte(b); sum += b;
      end
      b = w[7:0];
      send_byte(b); sum += b;
      if (is_i) begin
        ea = addr + 16'(i);
        ed = w;
      end else begin
        ea = {8'h00, addr[7:0] + 8'(i)};
        ed = {1'b0, w[7:0]};
      end
      exp_q.push_back(wr_t'{is_i, ea, ed, 32'(cyc)});
    end
    b = 8'h00 - sum;
    if (bad_sum) b = b + 8'h01;
    send_byte(b);
    idle(2);
    check("err_after_frame", err, bad_hi || bad_sum);
    check("busy_after_frame", busy, 0);
    compare_writes(is_i ? "imem" : "dmem");
  endtask

  initial begin
    logic [15:0] a;
    logic        ii;
    int          n;
    logic [7:0]  u;

    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST_N = 1'b1;
    idle(2);
    check_reset_outputs("post_reset");

    frame_words = '{9'h123, 9'h045};
    load_frame(1'b1, 16'h0010, 1'b0, 1'b0);

    frame_words = '{9'h0AA, 9'h0BB};
    load_frame(1'b0, 16'h00FF, 1'b0, 1'b0);

    frame_words = '{9'h123, 9'h045};
    load_frame(1'b1, 16'h0010, 1'b0, 1'b1);

    frame_words = '{9'h1C3, 9'h05A};
    load_frame(1'b1, 16'hFFFF, 1'b1, 1'b0);

    send_byte(8'h7E);
    idle(3);
    check("unknown_cmd_err", err, 1);
    check("unknown_cmd_busy", busy, 0);
    compare_writes("unknown");

    send_byte(8'h03);
    rx_valid = 1'b0;
    check("run_start", start, 1);
    check("run_rx_ready", rx_ready, 0);
    check("run_clears_err", err, 0);
    check("run_busy", busy, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
    end
    check("run_wait_start_low", start, 0);
    check("run_wait_not_done", {busy, done, rx_ready}, 3'b100);
    halt_program = 1'b1;
    @(posedge CLK);
    #1;
    halt_program = 1'b0;
    check("run_done", {busy, done, rx_ready}, 3'b011);

    halt_program = 1'b1;
    send_byte(8'h03);
    rx_valid = 1'b0;
    check("halt_early_start", {start, done}, 2'b10);
    @(posedge CLK);
    #1;
    check("halt_ignored_in_start", {start, busy, done}, 3'b010);
    @(posedge CLK);
    #1;
    halt_program = 1'b0;
    check("halt_early_done", {busy, done}, 2'b01);

    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    rx_valid = 1'b0;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("reset_mid_frame");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    idle(1);

    send_byte(8'h02); send_byte(8'h00); send_byte(8'h05); send_byte(8'h01); send_byte(8'hAA);
    rx_valid = 1'b0;
    check("strobe_before_reset", dmem_we, 1);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("reset_drops_strobe");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    idle(2);
    compare_writes("dropped");

    send_byte(8'h03);
    rx_valid = 1'b0;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("reset_mid_run");
    RST_N = 1'b1;
    idle(1);

    frame_words = '{9'h1FF, 9'h000, 9'h101};
    load_frame(1'b1, 16'h2000, 1'b0, 1'b0);

    gaps = 1'b1;
    for (int f = 0; f < 30; f++) begin
      ii = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      n  = $urandom_range(1, 9);
      if (f == 5)  begin ii = 1'b0; n = 256; end
      if (f == 11) begin ii = 1'b1; n = 256; a = 16'hFFF0; end
      frame_words.delete();
      for (int k = 0; k < n; k++) frame_words.push_back(ii ? 9'($urandom) : {1'b0, 8'($urandom)});
      load_frame(ii, a, ii && ($urandom_range(0, 5) == 0), $urandom_range(0, 5) == 0);
      if (f % 7 == 3) begin
        u = 8'($urandom_range(4, 255));
        send_byte(u);
        idle(2);
        check("rand_unknown_err", {err, busy}, 2'b10);
        compare_writes("rand_unknown");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
